// File: rtl/ascon_pkg.sv
// Shared types and widths for the Ascon ciphertext/tag byte serializer.
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CT,
        TAG_WAIT,
        TAG
    } ser_state_t;

    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned TAG_W       = 128;
    localparam int unsigned BLK_W       = 64;

endpackage

// File: rtl/ascon_ct_serializer.sv
// Serializes 64-bit ciphertext blocks and the AEAD tag into one MSB-first byte stream,
// absorbing byte-wide backpressure from the pin interface.
module ascon_ct_serializer
    import ascon_pkg::*;
#(
    parameter int unsigned TAG_BYTES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [BLK_W-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             tag_valid,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             busy,
    output logic             frame_done,
    output logic             tag_ovf
);

    localparam logic [3:0] CT_LAST  = 4'(BLOCK_BYTES - 1);
    localparam logic [3:0] TAG_LAST = 4'(TAG_BYTES - 1);

    ser_state_t       state_q, state_d;
    logic [TAG_W-1:0] shreg_q, shreg_d;
    logic [TAG_W-1:0] tag_reg_q;
    logic [3:0]       cnt_q, cnt_d;
    logic             blk_last_q, blk_last_d;
    logic             s_ready_q;
    logic             frame_done_q, frame_done_d;
    logic             tag_full_q, tag_full_d;
    logic             tag_taken_q, tag_taken_d;
    logic             tag_ovf_q, tag_ovf_d;
    logic             tag_clear;
    logic             tag_cap;
    logic             accept_in;
    logic             accept_out;

    assign accept_in  = s_axis_tvalid && s_ready_q;
    assign accept_out = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        blk_last_d   = blk_last_q;
        frame_done_d = 1'b0;
        tag_clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_in) begin
                    shreg_d    = {s_axis_tdata, {(TAG_W - BLK_W){1'b0}}};
                    blk_last_d = s_axis_tlast;
                    cnt_d      = 4'd0;
                    state_d    = CT;
                end
            end
            CT: begin
                if (accept_out) begin
                    shreg_d = shreg_q << 8;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == CT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = blk_last_q ? TAG_WAIT : IDLE;
                    end
                end
            end
            TAG_WAIT: begin
                if (tag_full_q) begin
                    shreg_d = tag_reg_q;
                    cnt_d   = 4'd0;
                    state_d = TAG;
                end
            end
            TAG: begin
                if (accept_out) begin
                    shreg_d = shreg_q << 8;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == TAG_LAST) begin
                        cnt_d        = 4'd0;
                        tag_clear    = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tag_taken masks a level tag_valid from re-capturing or flagging overflow
    // until the next frame's first block is accepted.
    always_comb begin
        tag_cap     = tag_valid && !tag_full_q && !tag_taken_q;
        tag_full_d  = tag_full_q;
        tag_taken_d = tag_taken_q;
        if (tag_clear) begin
            tag_full_d = 1'b0;
        end else if (tag_cap) begin
            tag_full_d = 1'b1;
        end
        if (tag_cap) begin
            tag_taken_d = 1'b1;
        end else if (accept_in) begin
            tag_taken_d = 1'b0;
        end
        tag_ovf_d = tag_ovf_q || (tag_valid && tag_full_q && !tag_taken_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            tag_reg_q    <= '0;
            cnt_q        <= 4'd0;
            blk_last_q   <= 1'b0;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            tag_full_q   <= 1'b0;
            tag_taken_q  <= 1'b0;
            tag_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            blk_last_q   <= blk_last_d;
            s_ready_q    <= (state_d == IDLE);
            frame_done_q <= frame_done_d;
            tag_full_q   <= tag_full_d;
            tag_taken_q  <= tag_taken_d;
            tag_ovf_q    <= tag_ovf_d;
            if (tag_cap) begin
                tag_reg_q <= tag_in;
            end
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = (state_q == CT) || (state_q == TAG);
    assign m_axis_tdata  = shreg_q[TAG_W-1 -: 8];
    assign m_axis_tuser  = (state_q == TAG);
    assign m_axis_tlast  = (state_q == TAG) && (cnt_q == TAG_LAST);
    assign busy          = (state_q != IDLE) || tag_full_q;
    assign frame_done    = frame_done_q;
    assign tag_ovf       = tag_ovf_q;

endmodule
